// File: rtl/tmds_lock_if.sv
// tmds_lock_if: control/status bundle between the TMDS bit-alignment
// controller and its surroundings.
//   pll_locked  recovered bit-clock PLL lock (clk domain)
//   tmds_d0     raw channel-0 10-bit word (clk domain)
//   phase       bit-phase select, 0..9
//   pll_delay   PLL fine delay, 0..15
//   locked      word alignment good
//   searching   controller is in SETTLE or DWELL
//   lost        one-cycle pulse on lock loss
//   sweep_count completed full 160-setting sweeps, saturating
// master: the receive path side; slave: the controller.
interface tmds_lock_if;
  logic       pll_locked;
  logic [9:0] tmds_d0;
  logic [3:0] phase;
  logic [3:0] pll_delay;
  logic       locked;
  logic       searching;
  logic       lost;
  logic [7:0] sweep_count;

  modport master (
    output pll_locked, tmds_d0,
    input  phase, pll_delay, locked, searching, lost, sweep_count
  );

  modport slave (
    input  pll_locked, tmds_d0,
    output phase, pll_delay, locked, searching, lost, sweep_count
  );
endinterface

// File: rtl/tmds_lock_controller.sv
// tmds_lock_controller: bit-alignment search for the TMDS receive path.
// Steps through (phase, pll_delay) settings, waits for the capture to settle,
// then counts control-period codes on channel 0 within a dwell window.
// Enough hits declare lock; a long hit-free stretch while locked drops back
// to a retry of the same setting.
// Ports:
//   clk      pixel clock, posedge
//   reset_n  asynchronous active-low reset
//   bus      tmds_lock_if.slave (pll_locked, tmds_d0 in; phase, pll_delay,
//            locked, searching, lost, sweep_count out)
module tmds_lock_controller #(
  parameter int unsigned SETTLE_CYCLES  = 64,
  parameter int unsigned WINDOW_CYCLES  = 4096,
  parameter int unsigned MIN_HITS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 262144
) (
  input  logic        clk,
  input  logic        reset_n,
  tmds_lock_if.slave  bus
);

  localparam int unsigned SET_W = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
  localparam int unsigned WIN_W = (WINDOW_CYCLES  > 1) ? $clog2(WINDOW_CYCLES)  : 1;
  localparam int unsigned HIT_W = $clog2(MIN_HITS + 1);
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [HIT_W-1:0] HIT_MAX  = HIT_W'(MIN_HITS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DWELL  = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [3:0]       phase_q, phase_d;
  logic [3:0]       pll_q, pll_d;
  logic [7:0]       sweep_q, sweep_d;
  logic             locked_q, locked_d;
  logic             search_q, search_d;
  logic             lost_q, lost_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [HIT_W-1:0] hits_q, hits_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic hit;
  assign hit = (bus.tmds_d0 == 10'h354) || (bus.tmds_d0 == 10'h0AB) ||
               (bus.tmds_d0 == 10'h154) || (bus.tmds_d0 == 10'h2AB);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    pll_d    = pll_q;
    sweep_d  = sweep_q;
    locked_d = locked_q;
    lost_d   = 1'b0;
    settle_d = settle_q;
    win_d    = win_q;
    hits_d   = hits_q;
    tmo_d    = tmo_q;

    if (!bus.pll_locked) begin
      state_d  = S_IDLE;
      locked_d = 1'b0;
      lost_d   = (state_q == S_LOCKED);
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end
        S_SETTLE: begin
          if (settle_q == SET_LAST) begin
            state_d = S_DWELL;
            win_d   = '0;
            hits_d  = '0;
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end
        S_DWELL: begin
          win_d = win_q + WIN_W'(1);
          if (hit && hits_q != HIT_MAX) hits_d = hits_q + HIT_W'(1);
          // Lock test uses this cycle's hit so a hit in the last window
          // cycle still counts before the advance decision.
          if (hit && (hits_q + HIT_W'(1) == HIT_MAX)) begin
            state_d  = S_LOCKED;
            locked_d = 1'b1;
            tmo_d    = '0;
          end else if (win_q == WIN_LAST) begin
            state_d  = S_SETTLE;
            settle_d = '0;
            win_d    = '0;
            if (phase_q == 4'd9) begin
              phase_d = '0;
              if (pll_q == 4'd15) begin
                pll_d = '0;
                if (sweep_q != '1) sweep_d = sweep_q + 8'd1;
              end else begin
                pll_d = pll_q + 4'd1;
              end
            end else begin
              phase_d = phase_q + 4'd1;
            end
          end
        end
        default: begin // S_LOCKED
          if (hit) begin
            tmo_d = '0;
          end else if (tmo_q == TMO_LAST) begin
            // Retry the same setting once before the search moves on.
            lost_d   = 1'b1;
            locked_d = 1'b0;
            state_d  = S_DWELL;
            win_d    = '0;
            hits_d   = '0;
            tmo_d    = '0;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      endcase
    end

    search_d = (state_d == S_SETTLE) || (state_d == S_DWELL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      pll_q    <= '0;
      sweep_q  <= '0;
      locked_q <= 1'b0;
      search_q <= 1'b0;
      lost_q   <= 1'b0;
      settle_q <= '0;
      win_q    <= '0;
      hits_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      pll_q    <= pll_d;
      sweep_q  <= sweep_d;
      locked_q <= locked_d;
      search_q <= search_d;
      lost_q   <= lost_d;
      settle_q <= settle_d;
      win_q    <= win_d;
      hits_q   <= hits_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.pll_delay   = pll_q;
  assign bus.sweep_count = sweep_q;
  assign bus.locked      = locked_q;
  assign bus.searching   = search_q;
  assign bus.lost        = lost_q;

endmodule

// File: tb/tb_tmds_lock_controller.sv
module tb_tmds_lock_controller;
  localparam int SETTLE = 4;
  localparam int WINDOW = 32;
  localparam int MINH   = 2;
  localparam int TMO    = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  tmds_lock_if bus ();

  tmds_lock_controller #(
    .SETTLE_CYCLES (SETTLE),
    .WINDOW_CYCLES (WINDOW),
    .MIN_HITS      (MINH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit is_ctrl(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  // ---------------- behavioural model ----------------
  // The search position is a single linear index: every failed window moves
  // it by one; phase, pll_delay and sweep_count are views of that index.
  int m_mode;      // 0 idle, 1 settle, 2 dwell, 3 locked
  int m_t;         // cycles spent in current settle/dwell
  int m_hits;      // hits seen in current window
  int m_since;     // consecutive hit-free cycles while locked
  int m_setting;   // number of advances since reset
  bit m_locked, m_lost, m_search;

  function automatic void model_reset();
    m_mode = 0; m_t = 0; m_hits = 0; m_since = 0; m_setting = 0;
    m_locked = 0; m_lost = 0; m_search = 0;
  endfunction

  function automatic void model_step(input bit pll, input bit h);
    m_lost = 0;
    if (!pll) begin
      if (m_mode == 3) m_lost = 1;
      m_mode = 0;
      m_locked = 0;
    end else begin
      case (m_mode)
        0: begin m_mode = 1; m_t = 0; end
        1: begin
          m_t++;
          if (m_t == SETTLE) begin m_mode = 2; m_t = 0; m_hits = 0; end
        end
        2: begin
          m_t++;
          if (h) m_hits++;
          if (m_hits >= MINH) begin
            m_mode = 3; m_locked = 1; m_since = 0;
          end else if (m_t == WINDOW) begin
            m_setting++; m_mode = 1; m_t = 0;
          end
        end
        default: begin
          if (h) m_since = 0;
          else begin
            m_since++;
            if (m_since == TMO) begin
              m_lost = 1; m_locked = 0; m_mode = 2; m_t = 0; m_hits = 0;
            end
          end
        end
      endcase
    end
    m_search = (m_mode == 1) || (m_mode == 2);
  endfunction

  function automatic int exp_phase();  return m_setting % 10; endfunction
  function automatic int exp_pll();    return (m_setting / 10) % 16; endfunction
  function automatic int exp_sweep();
    return (m_setting / 160 > 255) ? 255 : m_setting / 160;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step(bus.pll_locked, is_ctrl(bus.tmds_d0));
    end
  end

  // Single per-cycle compare process, away from the active edge.
  always @(negedge clk) begin
    chk("phase",       bus.phase,       exp_phase());
    chk("pll_delay",   bus.pll_delay,   exp_pll());
    chk("sweep_count", bus.sweep_count, exp_sweep());
    chk("locked",      bus.locked,      m_locked);
    chk("searching",   bus.searching,   m_search);
    chk("lost",        bus.lost,        m_lost);
  end

  // ---------------- stimulus ----------------
  int hitmode = 1;   // 0 none, 1 constant 2AB, 2 only at phase 7, 3 random
  int hitpct  = 5;
  logic [9:0] codes [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  function automatic logic [9:0] nonhit();
    logic [9:0] w;
    do w = 10'($urandom); while (is_ctrl(w));
    return w;
  endfunction

  function automatic logic [9:0] anyhit();
    return codes[$urandom_range(3)];
  endfunction

  initial begin
    bus.tmds_d0 = 10'h000;
    forever begin
      @(negedge clk);
      case (hitmode)
        0: bus.tmds_d0 = nonhit();
        1: bus.tmds_d0 = 10'h2AB;
        2: bus.tmds_d0 = (bus.phase == 4'd7) ? anyhit() : nonhit();
        default: bus.tmds_d0 = ($urandom_range(99) < hitpct) ? anyhit() : nonhit();
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_locked(input int budget, output int n);
    n = 0;
    while (!bus.locked && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  int n;
  int drop_len;

  initial begin
    bus.pll_locked = 1'b1;
    hitmode = 1;
    tick();
    chk("reset_phase",  bus.phase, 0);
    chk("reset_locked", bus.locked, 0);
    tick();
    reset_n = 1'b1;

    // Constant control word: lock on 2nd dwell cycle (1 + 4 + 2 edges).
    wait_locked(50, n);
    chk("lock_latency", n, 7);
    repeat (20) tick();
    chk("locked_hold",  bus.locked, 1);
    chk("search_low",   bus.searching, 0);

    // Hits stop: lost after TMO hit-free cycles, then retry same setting.
    hitmode = 0;
    n = 0;
    while (!bus.lost && n < 40) begin tick(); n++; end
    chk("lost_delay", n, 16);
    chk("lost_unlock", bus.locked, 0);
    hitmode = 1;
    tick();
    chk("lost_one_cycle", bus.lost, 0);
    wait_locked(40, n);
    chk("relock_latency", n + 1, 2);
    chk("relock_phase", bus.phase, 0);

    // pll_locked falls while locked.
    repeat (5) tick();
    bus.pll_locked = 1'b0;
    tick();
    chk("pll_drop_locked", bus.locked, 0);
    chk("pll_drop_lost",   bus.lost, 1);
    repeat (3) tick();
    bus.pll_locked = 1'b1;
    wait_locked(50, n);
    chk("pll_relock_latency", n, 7);

    // Hits only at phase 7: 7 failed settings then lock.
    hitmode = 2;
    do_reset();
    wait_locked(400, n);
    chk("p7_latency", n, 259);
    chk("p7_phase", bus.phase, 7);
    chk("p7_pll",   bus.pll_delay, 0);
    chk("p7_sweep", bus.sweep_count, 0);

    // No hits: async reset mid-dwell at phase 5, then a full sweep.
    hitmode = 0;
    do_reset();
    repeat (190) tick();
    chk("pre_rst_phase",  bus.phase, 5);
    chk("pre_rst_search", bus.searching, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_phase",  bus.phase, 0);
    chk("async_pll",    bus.pll_delay, 0);
    chk("async_search", bus.searching, 0);
    tick();
    reset_n = 1'b1;
    repeat (5760) tick();
    chk("sweep_before",  bus.sweep_count, 0);
    chk("sweep_b_phase", bus.phase, 9);
    chk("sweep_b_pll",   bus.pll_delay, 15);
    tick();
    chk("sweep_after",   bus.sweep_count, 1);
    chk("sweep_a_phase", bus.phase, 0);
    chk("sweep_a_pll",   bus.pll_delay, 0);
    repeat (36) tick();
    chk("sweep_next_phase", bus.phase, 1);
    chk("sweep_locked",     bus.locked, 0);

    // Randomized traffic with occasional PLL drops.
    hitmode = 3;
    do_reset();
    drop_len = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) hitpct = $urandom_range(1, 15);
      if (drop_len > 0) begin
        drop_len--;
        if (drop_len == 0) bus.pll_locked = 1'b1;
      end else if ($urandom_range(299) == 0) begin
        bus.pll_locked = 1'b0;
        drop_len = $urandom_range(1, 6);
      end
      tick();
    end

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tmds_lock_controller.md
Name: tmds_lock_controller

Overview:
- Sequences bit-alignment search for the TMDS receive path.
- Drives the 4-bit bit-phase select (word-capture strobe position, 0..9) and the 4-bit PLL fine delay.
- Monitors the raw channel-0 10-bit word in the pixel clock domain for the four control-period codes.
- Declares lock, supervises lock, and re-acquires on loss; it is the single owner of phase and pll_delay.

Parameters:
- SETTLE_CYCLES, 64: wait after any phase/pll_delay change before sampling.
- WINDOW_CYCLES, 4096: dwell window length per candidate setting.
- MIN_HITS, 4: control-word hits within one window needed to declare lock.
- TIMEOUT_CYCLES, 262144: hit-free cycles in LOCKED before lock is declared lost.

Ports:
- clk  in  1  TMDS pixel clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  recovered bit-clock PLL lock, synchronous to clk.
- tmds_d0  in  10  raw channel-0 word, clk domain.
- phase  out  4  bit-phase select, 0..9.
- pll_delay  out  4  PLL fine delay, 0..15.
- locked  out  1  word alignment good.
- searching  out  1  high in SETTLE or DWELL.
- lost  out  1  one-cycle pulse on lock loss.
- sweep_count  out  8  completed full sweeps (160 settings), saturating.

Behaviour:
- Reset values (async on reset_n low): state IDLE; phase 0; pll_delay 0; locked 0; searching 0; lost 0; sweep_count 0; all internal counters 0.
- Hit: tmds_d0 equals 10'h354, 10'h0AB, 10'h154 or 10'h2AB. Compared combinationally and counted on the same edge. TERC4 and data words are not hits.
- IDLE:
  - On pll_locked=1, go to SETTLE with settle counter cleared.
  - phase and pll_delay keep their current values.
- SETTLE:
  - Count SETTLE_CYCLES cycles, ignoring hits.
  - Then go to DWELL with window counter and hit counter cleared.
- DWELL:
  - Window counter increments each cycle; hit counter increments on each hit, saturating at MIN_HITS.
  - On the edge where the hit count reaches MIN_HITS, go to LOCKED; locked<=1 on that same edge. Early exit is allowed before the window ends.
  - A hit in the last window cycle counts.
  - If the window ends with hits < MIN_HITS, advance the setting and go to SETTLE.
- Advance order:
  - phase increments; 9 wraps to 0 and increments pll_delay.
  - pll_delay 15 wraps to 0 and increments sweep_count (saturates at 255).
  - phase never takes values 10..15.
- LOCKED:
  - Timeout counter clears on every hit and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 with no hit on that cycle: lost pulses 1 for one cycle, locked<=0, go to DWELL with the same phase/pll_delay (one retry before advancing). Window and hit counters clear.
- pll_locked falling in any state:
  - Next edge: state IDLE, locked 0, searching 0.
  - lost pulses only if the state was LOCKED.
  - phase/pll_delay are retained.
- searching is a registered function of next state: 1 for SETTLE/DWELL.
- Output changes: phase/pll_delay change only on the advance edge. They are never changed while locked=1.
- Reset mid-search returns all outputs to reset values immediately, without waiting for a clock edge.
- Counter widths: derived with $clog2 of the respective parameter. No overflow is possible, since each counter is cleared at its terminal value.

Test Plan:
(Bench overrides: SETTLE_CYCLES=4, WINDOW_CYCLES=32, MIN_HITS=2, TIMEOUT_CYCLES=16.)
- Reset with pll_locked=1 and tmds_d0=10'h2AB constantly -> phase stays 0, locked=1 on the 2nd DWELL cycle (SETTLE 4 cycles + 2), searching=0 after, lost never pulses.
- tmds_d0 drives hits only when phase==7 -> phase advances through 0..6 at one step per 36 cycles; lock at phase=7, pll_delay=0, sweep_count=0.
- No hits at all for 10 × 16 + 1 setting windows -> phase wraps 9→0 with pll_delay incrementing; after pll_delay 15→0, sweep_count=1; locked stays 0.
- Locked, then hits stop -> lost pulses exactly one cycle 16 cycles after the last hit, locked=0, same phase/pll_delay retried; if hits resume within the window, re-lock without an advance.
- Locked, deassert pll_locked -> next edge locked=0, lost=1 for one cycle, state IDLE. Reassert -> SETTLE from the retained phase.
- Assert reset_n=0 in mid-DWELL at phase=5 -> phase=0, pll_delay=0, searching=0 asynchronously, before the next clk edge.
